// File: rtl/scan_chain_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } scan_state_t;

    localparam int SCAN_CAPTURE_CYCLES = 1;

endpackage

// File: rtl/scan_shreg.sv
// Parameterised shift register with synchronous clear, parallel load and
// MSB-ward serial shift.
module scan_shreg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    // Register update: clear has priority over load, load over shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test initiator: shifts one pattern into an SDFF chain, captures,
// unloads the response and compares it against an expected value under mask.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic [CHAIN_LEN-1:0] PAT,
    input  logic [CHAIN_LEN-1:0] EXP,
    input  logic [CHAIN_LEN-1:0] MASK,
    input  logic                 SO_IN,
    output logic                 SE_OUT,
    output logic                 SI_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [CHAIN_LEN-1:0] RESP,
    output logic [CHAIN_LEN-1:0] FAIL_BITS
);
    import scan_ctrl_pkg::*;

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);

    scan_state_t          state_r, state_n;
    logic [CNT_W-1:0]     cnt_r, cnt_n;
    logic                 se_r, se_n, busy_r, busy_n, done_r, done_n;
    logic                 accept_s, last_s, pass_r;
    logic [CHAIN_LEN-1:0] exp_r, mask_r, fail_r;
    logic [CHAIN_LEN-1:0] pat_q_s, resp_next_s, fail_next_s;
    logic                 pat_unused_s;

    // Next-state, counter and control-output decode
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, scan_ctrl_pkg::DONE: begin
                if (START) begin
                    accept_s = 1'b1;
                    state_n  = SHIFT;
                    cnt_n    = CNT_W'(CHAIN_LEN - 1);
                end else begin
                    state_n  = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == '0) begin
                    state_n = CAPTURE;
                    cnt_n   = CNT_W'(SCAN_CAPTURE_CYCLES - 1);
                end else begin
                    cnt_n   = cnt_r - CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (cnt_r == '0) begin
                    state_n = UNLOAD;
                    cnt_n   = CNT_W'(CHAIN_LEN - 1);
                end else begin
                    cnt_n   = cnt_r - CNT_W'(1);
                end
            end
            UNLOAD: begin
                if (cnt_r == '0) begin
                    state_n = scan_ctrl_pkg::DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        se_n   = (state_n == SHIFT) || (state_n == UNLOAD);
        busy_n = (state_n == SHIFT) || (state_n == CAPTURE) || (state_n == UNLOAD);
        done_n = (state_n == scan_ctrl_pkg::DONE);
    end

    // State, counter and control-output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            se_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            se_r    <= se_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    // The verdict is taken on the edge of the last unload sample, so it
    // must include the bit arriving on that same edge.
    assign last_s      = (state_r == UNLOAD) && (cnt_r == '0);
    assign resp_next_s = {RESP[CHAIN_LEN-2:0], SO_IN};
    assign fail_next_s = (resp_next_s ^ exp_r) & mask_r;

    // Expected/mask latch and pass/fail result registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_r  <= '0;
            mask_r <= '0;
            fail_r <= '0;
            pass_r <= 1'b0;
        end else if (accept_s) begin
            exp_r  <= EXP;
            mask_r <= MASK;
            fail_r <= '0;
            pass_r <= 1'b0;
        end else if (last_s) begin
            fail_r <= fail_next_s;
            pass_r <= (fail_next_s == '0);
        end else begin
            fail_r <= fail_r;
            pass_r <= pass_r;
        end
    end

    // Stimulus register: MSB drives SI; zeros fill in behind the pattern,
    // which keeps SI low through capture and unload.
    scan_shreg #(.W(CHAIN_LEN)) u_pat_shreg (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (1'b0),
        .load  (accept_s),
        .shift (state_r == SHIFT),
        .sin   (1'b0),
        .din   (PAT),
        .q     (pat_q_s)
    );

    scan_shreg #(.W(CHAIN_LEN)) u_resp_shreg (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (accept_s),
        .load  (1'b0),
        .shift (state_r == UNLOAD),
        .sin   (SO_IN),
        .din   ({CHAIN_LEN{1'b0}}),
        .q     (RESP)
    );

    // Only the MSB of the stimulus register leaves the block.
    assign pat_unused_s = ^pat_q_s[CHAIN_LEN-2:0];

    assign SE_OUT    = se_r;
    assign SI_OUT    = pat_q_s[CHAIN_LEN-1];
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign PASS      = pass_r;
    assign FAIL_BITS = fail_r;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a 3-flop SDFF chain model and
// a pattern-level reference model compared every cycle.
module tb_scan_chain_ctrl;

    localparam int N = 3;

    logic         CLK = 1'b0;
    logic         RST_N, START, SO_IN;
    logic [N-1:0] PAT, EXP, MASK, CAP;
    logic         SE_OUT, SI_OUT, BUSY, DONE, PASS;
    logic [N-1:0] RESP, FAIL_BITS;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N-1:0] chain_q = '0;
    logic [N-1:0] si_seq;

    int           t_m;
    logic [N-1:0] pat_m, exp_m, mask_m, cap_m, resp_h, fail_h;
    logic         pass_h;

    scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .PAT       (PAT),
        .EXP       (EXP),
        .MASK      (MASK),
        .SO_IN     (SO_IN),
        .SE_OUT    (SE_OUT),
        .SI_OUT    (SI_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PASS      (PASS),
        .RESP      (RESP),
        .FAIL_BITS (FAIL_BITS)
    );

    always #5 CLK = ~CLK;

    // SDFF chain: flop 0 nearest SI, flop N-1 drives SO
    always @(posedge CLK) chain_q <= SE_OUT ? {chain_q[N-2:0], SI_OUT} : CAP;
    assign SO_IN = chain_q[N-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic in_rng(input int t, input int lo, input int hi);
        return (t >= lo) && (t <= hi);
    endfunction

    function automatic logic si_ref(input int t, input logic [N-1:0] p);
        if (in_rng(t, 1, N)) return p[N - t];
        return 1'b0;
    endfunction

    // Partial response during unload: the captured word enters MSB-first.
    function automatic logic [N-1:0] resp_ref(input int t, input logic [N-1:0] c,
                                              input logic [N-1:0] h);
        if (t == 0) return h;
        if (t <= N + 2) return '0;
        return c >> (2 * N + 2 - t);
    endfunction

    // Reference model: t_m is the cycle index within a pattern (0 = idle)
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            t_m <= 0; pat_m <= '0; exp_m <= '0; mask_m <= '0; cap_m <= '0;
            resp_h <= '0; fail_h <= '0; pass_h <= 1'b0;
        end else begin
            if (START && (t_m == 0 || t_m == 2 * N + 2)) begin
                t_m <= 1; pat_m <= PAT; exp_m <= EXP; mask_m <= MASK;
                resp_h <= '0; fail_h <= '0; pass_h <= 1'b0;
            end else if (t_m == 2 * N + 2) begin
                t_m <= 0;
            end else if (t_m != 0) begin
                t_m <= t_m + 1;
            end
            if (t_m == N + 1) cap_m <= CAP;
            if (t_m == 2 * N + 1) begin
                resp_h <= cap_m;
                fail_h <= (cap_m ^ exp_m) & mask_m;
                pass_h <= (((cap_m ^ exp_m) & mask_m) == '0);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        chk("busy",  32'(BUSY),   32'(in_rng(t_m, 1, 2 * N + 1)));
        chk("se",    32'(SE_OUT), 32'(in_rng(t_m, 1, N) || in_rng(t_m, N + 2, 2 * N + 1)));
        chk("si",    32'(SI_OUT), 32'(si_ref(t_m, pat_m)));
        chk("done",  32'(DONE),   32'(t_m == 2 * N + 2));
        chk("resp",  32'(RESP),   32'(resp_ref(t_m, cap_m, resp_h)));
        chk("pass",  32'(PASS),   32'(pass_h));
        chk("fbits", 32'(FAIL_BITS), 32'(fail_h));
        if (t_m == N + 1) chk("chain_loaded", 32'(chain_q), 32'(pat_m));
    end

    // Applies one pattern and returns at the negedge of the DONE cycle
    task automatic run(input logic [N-1:0] p, input logic [N-1:0] e,
                       input logic [N-1:0] m, input logic [N-1:0] c);
        @(negedge CLK);
        PAT = p; EXP = e; MASK = m; CAP = c; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        si_seq[N-1] = SI_OUT;
        for (int k = 2; k <= N; k++) begin
            @(negedge CLK);
            si_seq[N-k] = SI_OUT;
        end
        repeat (N + 2) @(negedge CLK);
        chk("done_at_cycle8", 32'(DONE), 32'd1);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; PAT = '0; EXP = '0; MASK = '0; CAP = '0;
        repeat (2) @(negedge CLK);
        chk("rst_se",   32'(SE_OUT), 32'd0);
        chk("rst_busy", 32'(BUSY),   32'd0);
        chk("rst_pass", 32'(PASS),   32'd0);
        chk("rst_resp", 32'(RESP),   32'd0);
        #1 RST_N = 1'b1;

        // Matching capture, full mask
        run(3'b110, 3'b011, 3'b111, 3'b011);
        chk("t1_si_seq", 32'(si_seq),    32'(3'b110));
        chk("t1_pass",   32'(PASS),      32'd1);
        chk("t1_resp",   32'(RESP),      32'(3'b011));
        chk("t1_fbits",  32'(FAIL_BITS), 32'(3'b000));
        chk("t1_busy",   32'(BUSY),      32'd0);

        // Single-bit mismatch, then masked out
        run(3'b011, 3'b011, 3'b111, 3'b001);
        chk("t2_pass",  32'(PASS),      32'd0);
        chk("t2_fbits", 32'(FAIL_BITS), 32'(3'b010));
        run(3'b011, 3'b011, 3'b101, 3'b001);
        chk("t3_pass",  32'(PASS),      32'd1);
        chk("t3_fbits", 32'(FAIL_BITS), 32'(3'b000));
        chk("t3_resp",  32'(RESP),      32'(3'b001));

        // Async reset between edges clears held results without a clock
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_pass", 32'(PASS), 32'd0);
        chk("arst_resp", 32'(RESP), 32'd0);
        @(negedge CLK);
        #1 RST_N = 1'b1;

        // START while busy is ignored; reset in cycle 6 aborts
        @(negedge CLK);
        PAT = 3'b101; EXP = 3'b110; MASK = 3'b111; CAP = 3'b110; START = 1'b1;
        @(negedge CLK); START = 1'b0; si_seq[2] = SI_OUT;
        @(negedge CLK); si_seq[1] = SI_OUT;
        @(negedge CLK); si_seq[0] = SI_OUT; PAT = 3'b010; START = 1'b1;
        @(negedge CLK); START = 1'b0;
        chk("t4_si_seq", 32'(si_seq), 32'(3'b101));
        chk("t4_se_capture", 32'(SE_OUT), 32'd0);
        repeat (2) @(negedge CLK);
        chk("t4_resp_partial", 32'(RESP), 32'(3'b001));
        #1 RST_N = 1'b0;
        #1;
        chk("t4_abort_se",   32'(SE_OUT), 32'd0);
        chk("t4_abort_busy", 32'(BUSY),   32'd0);
        chk("t4_abort_done", 32'(DONE),   32'd0);
        chk("t4_abort_resp", 32'(RESP),   32'd0);
        repeat (3) @(negedge CLK);
        #1 RST_N = 1'b1;
        run(3'b011, 3'b101, 3'b111, 3'b101);
        chk("t4_fresh_si", 32'(si_seq), 32'(3'b011));
        chk("t4_fresh_pass", 32'(PASS), 32'd1);

        // Back-to-back: START held in the DONE cycle
        run(3'b110, 3'b010, 3'b011, 3'b010);
        chk("t5_first_pass", 32'(PASS), 32'd1);
        chk("t5_first_resp", 32'(RESP), 32'(3'b010));
        PAT = 3'b011; EXP = 3'b100; MASK = 3'b111; CAP = 3'b100; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("t5_b2b_busy", 32'(BUSY),   32'd1);
        chk("t5_b2b_se",   32'(SE_OUT), 32'd1);
        chk("t5_b2b_si",   32'(SI_OUT), 32'd0);
        chk("t5_b2b_pass", 32'(PASS),   32'd0);
        chk("t5_b2b_resp", 32'(RESP),   32'(3'b000));
        repeat (2 * N + 1) @(negedge CLK);
        chk("t5_second_done", 32'(DONE), 32'd1);
        chk("t5_second_pass", 32'(PASS), 32'd1);
        chk("t5_second_resp", 32'(RESP), 32'(3'b100));

        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
